// File: rtl/msg_pakout_pkg.sv
// Shared field widths and FSM state types for the message-to-packet serializer.
package msg_pakout_pkg;

  localparam int NS_ADDRESS_SIZE = 6;
  localparam int NS_DATA_SIZE    = 4;
  localparam int NS_REDUN_SIZE   = 4;
  localparam int NS_PACKET_SIZE  = 4;

  typedef enum logic {
    I_IDLE,
    I_ACK
  } istate_t;

  typedef enum logic [1:0] {
    O_IDLE,
    O_REQ,
    O_REL
  } ostate_t;

endpackage

// File: rtl/msg_pakout_calc_redun.sv
// Redundancy code of a message: XOR fold of {src, dst, dat} in RSZ-bit chunks.
// Purely combinational; no handshake.
module msg_pakout_calc_redun #(
  parameter int ASZ = 6,
  parameter int DSZ = 4,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);

  localparam int IW  = 2*ASZ + DSZ;
  localparam int NCH = (IW + RSZ - 1) / RSZ;

  logic [NCH*RSZ-1:0] padded;

  always_comb begin
    padded         = '0;
    padded[IW-1:0] = {src, dst, dat};
    red            = '0;
    for (int k = 0; k < NCH; k++) begin
      red = red ^ padded[k*RSZ +: RSZ];
    end
  end

endmodule

// File: rtl/msg_pakout.sv
// Serializes four-phase messages into TOT_PKS PSZ-bit packets (LSB first) via a one-message hold buffer.
// Registered outputs; i_ack withheld while the hold buffer is full, each packet waits for its o_ack cycle.
module msg_pakout
  import msg_pakout_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE,
  parameter int PSZ = NS_PACKET_SIZE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i_src,
  input  logic [ASZ-1:0] i_dst,
  input  logic [DSZ-1:0] i_dat,
  input  logic [RSZ-1:0] i_red,
  input  logic           i_req,
  output logic           i_ack,
  output logic [PSZ-1:0] o_pak,
  output logic           o_req,
  input  logic           o_ack,
  output logic           err_red,
  output logic           busy
);

  localparam int MSZ     = 2*ASZ + DSZ + RSZ;
  localparam int TOT_PKS = MSZ / PSZ + 1;
  localparam int WW      = TOT_PKS * PSZ;
  localparam int IDXW    = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TOT_PKS - 1);

  istate_t        istate_q, istate_d;
  ostate_t        ostate_q, ostate_d;
  logic           i_ack_q, i_ack_d;
  logic [MSZ-1:0] hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [WW-1:0]  shift_q, shift_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic           o_req_q, o_req_d;
  logic [PSZ-1:0] o_pak_q, o_pak_d;
  logic           err_red_q, err_red_d;
  logic           busy_q, busy_d;
  logic           hold_put, hold_take;
  logic [WW-1:0]  load_w;
  logic [RSZ-1:0] red_calc;

  msg_pakout_calc_redun #(
    .ASZ(ASZ),
    .DSZ(DSZ),
    .RSZ(RSZ)
  ) u_calc_redun (
    .src(i_src),
    .dst(i_dst),
    .dat(i_dat),
    .red(red_calc)
  );

  always_comb begin
    istate_d  = istate_q;
    i_ack_d   = i_ack_q;
    hold_d    = hold_q;
    hold_put  = 1'b0;
    err_red_d = err_red_q;
    case (istate_q)
      I_IDLE: begin
        if (i_req && !hold_full_q) begin
          hold_d   = {i_src, i_dst, i_dat, i_red};
          hold_put = 1'b1;
          i_ack_d  = 1'b1;
          istate_d = I_ACK;
          if (i_red != red_calc) err_red_d = 1'b1;
        end
      end
      I_ACK: begin
        if (!i_req) begin
          i_ack_d  = 1'b0;
          istate_d = I_IDLE;
        end
      end
      default: istate_d = I_IDLE;
    endcase
  end

  // Load and write never coincide: writes need hold empty, loads need hold full.
  always_comb begin
    ostate_d  = ostate_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    o_req_d   = o_req_q;
    o_pak_d   = o_pak_q;
    hold_take = 1'b0;
    load_w    = '0;
    case (ostate_q)
      O_IDLE: begin
        if (hold_full_q) hold_take = 1'b1;
      end
      O_REQ: begin
        if (o_ack) begin
          o_req_d  = 1'b0;
          ostate_d = O_REL;
        end
      end
      O_REL: begin
        if (!o_ack) begin
          if (idx_q < LAST_IDX) begin
            idx_d    = idx_q + IDXW'(1);
            o_pak_d  = shift_q[PSZ-1:0];
            shift_d  = shift_q >> PSZ;
            o_req_d  = 1'b1;
            ostate_d = O_REQ;
          end else if (hold_full_q) begin
            hold_take = 1'b1;
          end else begin
            ostate_d = O_IDLE;
          end
        end
      end
      default: ostate_d = O_IDLE;
    endcase
    if (hold_take) begin
      load_w[MSZ-1:0] = hold_q;
      o_pak_d  = load_w[PSZ-1:0];
      shift_d  = load_w >> PSZ;
      idx_d    = '0;
      o_req_d  = 1'b1;
      ostate_d = O_REQ;
    end
  end

  assign hold_full_d = hold_put | (hold_full_q & ~hold_take);
  assign busy_d      = hold_full_d | (ostate_d != O_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      istate_q    <= I_IDLE;
      ostate_q    <= O_IDLE;
      i_ack_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      o_req_q     <= 1'b0;
      o_pak_q     <= '0;
      err_red_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      istate_q    <= istate_d;
      ostate_q    <= ostate_d;
      i_ack_q     <= i_ack_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      o_req_q     <= o_req_d;
      o_pak_q     <= o_pak_d;
      err_red_q   <= err_red_d;
      busy_q      <= busy_d;
    end
  end

  assign i_ack   = i_ack_q;
  assign o_req   = o_req_q;
  assign o_pak   = o_pak_q;
  assign err_red = err_red_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_msg_pakout.sv
// Bench for msg_pakout: message driver, packet acker with scoreboard, o_pak stability monitor.
// Defaults ASZ=6 DSZ=4 RSZ=4 PSZ=4 give 6 packets per message.
module tb_msg_pakout;

  localparam int ASZ = 6;
  localparam int DSZ = 4;
  localparam int RSZ = 4;
  localparam int PSZ = 4;

  typedef struct {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    bit             flip;
    bit             exp_err;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [ASZ-1:0] i_src = '0;
  logic [ASZ-1:0] i_dst = '0;
  logic [DSZ-1:0] i_dat = '0;
  logic [RSZ-1:0] i_red = '0;
  logic           i_req = 1'b0;
  logic           i_ack;
  logic [PSZ-1:0] o_pak;
  logic           o_req;
  logic           o_ack = 1'b0;
  logic           err_red;
  logic           busy;

  msg_pakout #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .PSZ(PSZ)) dut (
    .clk(clk), .reset(reset),
    .i_src(i_src), .i_dst(i_dst), .i_dat(i_dat), .i_red(i_red),
    .i_req(i_req), .i_ack(i_ack),
    .o_pak(o_pak), .o_req(o_req), .o_ack(o_ack),
    .err_red(err_red), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [PSZ-1:0] sb[$];
  logic [PSZ-1:0] got[$];
  int             rise_c[$];
  int             drop_c[$];
  bit             ack_en = 1'b1;
  bit             rand_dly = 1'b0;
  int             ack_dly = 0;
  bit             stab_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference redundancy: bit j of {src,dst,dat} folds into bit j mod RSZ.
  function automatic logic [RSZ-1:0] redun(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                                           input logic [DSZ-1:0] da);
    logic [2*ASZ+DSZ-1:0] v;
    logic [RSZ-1:0]       r;
    v = {s, d, da};
    r = '0;
    for (int j = 0; j < 2*ASZ+DSZ; j++) r[j % RSZ] = r[j % RSZ] ^ v[j];
    return r;
  endfunction

  task automatic push_exp(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                          input logic [DSZ-1:0] da, input logic [RSZ-1:0] r);
    logic [23:0] w;
    w = {4'h0, s, d, da, r};
    for (int k = 0; k < 6; k++) sb.push_back(w[k*4 +: 4]);
  endtask

  task automatic log_pkt();
    got.push_back(o_pak);
    rise_c.push_back(cyc);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pkt: got %0h expected no packet (cycle %0d)", o_pak, cyc);
    end else begin
      check("sb_pkt", 32'(o_pak), 32'(sb.pop_front()));
    end
  endtask

  // Packet acker: logs each packet when o_req is first seen, acks after a delay.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (reset) begin
        o_ack = 1'b0;
      end else if (ack_en && o_req && !o_ack) begin
        log_pkt();
        d = rand_dly ? int'($urandom_range(0, 7)) : ack_dly;
        for (int i = 0; i < d && !reset; i++) @(negedge clk);
        o_ack = reset ? 1'b0 : 1'b1;
      end else if (ack_en && o_ack && !o_req) begin
        o_ack = 1'b0;
        drop_c.push_back(cyc);
      end
    end
  end

  // o_pak may only change on the edge where o_req rises.
  initial begin
    logic [PSZ-1:0] prev_pak;
    logic           prev_req;
    logic           prev_rst;
    prev_pak = '0;
    prev_req = 1'b0;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && !prev_rst && o_pak !== prev_pak && !(o_req && !prev_req)) stab_bad = 1'b1;
      prev_pak = o_pak;
      prev_req = o_req;
      prev_rst = reset;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  task automatic send_msg(input logic [ASZ-1:0] s, input logic [ASZ-1:0] d,
                          input logic [DSZ-1:0] da, input bit flip);
    int n;
    logic [RSZ-1:0] r;
    r = redun(s, d, da) ^ {{(RSZ-1){1'b0}}, flip};
    i_src = s; i_dst = d; i_dat = da; i_red = r; i_req = 1'b1;
    push_exp(s, d, da, r);
    n = 0;
    while (!i_ack && n < 500) begin @(negedge clk); n++; end
    check("msg_ack", 32'(i_ack), 1);
    i_req = 1'b0;
    n = 0;
    while (i_ack && n < 50) begin @(negedge clk); n++; end
    check("msg_ack_fall", 32'(i_ack), 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((sb.size() != 0 || busy || o_req || o_ack) && n < 3000);
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles (pending=%0d busy=%0b), required idle", name, n, sb.size(), busy);
    end
  endtask

  task automatic man_ack();
    int n;
    n = 0;
    while (!o_req && n < 100) begin @(negedge clk); n++; end
    if (!o_req) begin
      checks++; failures++;
      $display("FAIL man_req: o_req=0 after %0d cycles, required 1", n);
    end else begin
      log_pkt();
    end
    o_ack = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (o_req && n < 100);
    o_ack = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] t1_exp [6];
    logic [3:0] t2_exp [6];
    vec_t tbl [8];
    t1_exp = '{4'h8, 4'h5, 4'h1, 4'hC, 4'h0, 4'h0};
    t2_exp = '{4'h9, 4'h5, 4'h1, 4'hC, 4'h0, 4'h0};
    tbl[0] = '{6'd3,  6'd1,  4'd5,  1'b0, 1'b0};
    tbl[1] = '{6'd63, 6'd0,  4'd15, 1'b0, 1'b0};
    tbl[2] = '{6'd0,  6'd63, 4'd0,  1'b0, 1'b0};
    tbl[3] = '{6'd21, 6'd42, 4'd10, 1'b0, 1'b0};
    tbl[4] = '{6'd5,  6'd9,  4'd3,  1'b1, 1'b1};
    tbl[5] = '{6'd1,  6'd2,  4'd4,  1'b0, 1'b1};
    tbl[6] = '{6'd63, 6'd63, 4'd15, 1'b0, 1'b1};
    tbl[7] = '{6'd0,  6'd0,  4'd0,  1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_i_ack", 32'(i_ack), 0);
    check("rst_o_req", 32'(o_req), 0);
    check("rst_o_pak", 32'(o_pak), 0);
    check("rst_err_red", 32'(err_red), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single message, zero-latency acker.
    got.delete(); rise_c.delete();
    i_src = 6'd3; i_dst = 6'd1; i_dat = 4'd5; i_red = 4'h8; i_req = 1'b1;
    push_exp(6'd3, 6'd1, 4'd5, 4'h8);
    @(negedge clk);
    check("t1_i_ack_t1", 32'(i_ack), 1);
    check("t1_o_req_t1", 32'(o_req), 0);
    @(negedge clk);
    check("t1_o_req_t2", 32'(o_req), 1);
    check("t1_pak0_t2", 32'(o_pak), 8);
    i_req = 1'b0;
    @(negedge clk);
    check("t1_i_ack_fall", 32'(i_ack), 0);
    wait_idle("t1_drain");
    check("t1_err_red", 32'(err_red), 0);
    check("t1_npk", 32'(got.size()), 6);
    for (int k = 0; k < 6; k++) check($sformatf("t1_pak%0d", k), 32'(got[k]), 32'(t1_exp[k]));
    check("t1_throughput", 32'(rise_c[5] - rise_c[0]), 10);

    // Redundancy error, then sticky across a good message.
    got.delete();
    i_src = 6'd3; i_dst = 6'd1; i_dat = 4'd5; i_red = 4'h9; i_req = 1'b1;
    push_exp(6'd3, 6'd1, 4'd5, 4'h9);
    @(negedge clk);
    check("t2_err_t1", 32'(err_red), 1);
    i_req = 1'b0;
    wait_idle("t2_drain");
    check("t2_npk", 32'(got.size()), 6);
    for (int k = 0; k < 6; k++) check($sformatf("t2_pak%0d", k), 32'(got[k]), 32'(t2_exp[k]));
    send_msg(6'd3, 6'd1, 4'd5, 1'b0);
    wait_idle("t2_drain_good");
    check("t2_err_sticky", 32'(err_red), 1);

    // Table vectors then random traffic with random ack delays.
    reset = 1'b1; repeat (2) @(negedge clk); reset = 1'b0; @(negedge clk);
    check("err_cleared", 32'(err_red), 0);
    rand_dly = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got.delete();
      send_msg(tbl[i].src, tbl[i].dst, tbl[i].dat, tbl[i].flip);
      wait_idle($sformatf("tbl%0d_drain", i));
      check($sformatf("tbl%0d_err", i), 32'(err_red), 32'(tbl[i].exp_err));
      check($sformatf("tbl%0d_npk", i), 32'(got.size()), 6);
    end
    got.delete();
    for (int i = 0; i < 12; i++)
      send_msg(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)), 1'b0);
    wait_idle("rand_drain");
    check("rand_npk", 32'(got.size()), 72);
    rand_dly = 1'b0;

    // Back-to-back with a slow acker; third message blocked on the hold buffer.
    ack_dly = 10;
    got.delete(); rise_c.delete(); drop_c.delete();
    send_msg(6'd10, 6'd20, 4'd3, 1'b0);
    send_msg(6'd7, 6'd33, 4'd12, 1'b0);
    check("t3_overlap", 32'(got.size() < 6), 1);
    check("t3_busy", 32'(busy), 1);
    i_src = 6'd50; i_dst = 6'd17; i_dat = 4'd9; i_red = redun(6'd50, 6'd17, 4'd9); i_req = 1'b1;
    push_exp(6'd50, 6'd17, 4'd9, redun(6'd50, 6'd17, 4'd9));
    repeat (3) @(negedge clk);
    check("t3_c_held", 32'(i_ack), 0);
    n = 0;
    while (!i_ack && n < 400) begin @(negedge clk); n++; end
    check("t3_c_ack", 32'(i_ack), 1);
    check("t3_c_ack_when", 32'(got.size()), 7);
    i_req = 1'b0;
    n = 0;
    while (i_ack && n < 50) begin @(negedge clk); n++; end
    check("t3_c_ack_fall", 32'(i_ack), 0);
    wait_idle("t3_drain");
    check("t3_npk", 32'(got.size()), 18);
    check("t3_b2b_gap", 32'(rise_c[6] - drop_c[5]), 1);

    // Reset while packet 3 is awaiting its ack.
    ack_dly = 6;
    got.delete();
    send_msg(6'd12, 6'd34, 4'd9, 1'b0);
    n = 0;
    while (got.size() < 4 && n < 300) begin @(negedge clk); n++; end
    @(negedge clk);
    check("t5_pre_o_req", 32'(o_req), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_o_req", 32'(o_req), 0);
    check("t5_i_ack", 32'(i_ack), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_o_pak", 32'(o_pak), 0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete(); got.delete();
    @(negedge clk);
    send_msg(6'd40, 6'd2, 4'd6, 1'b0);
    wait_idle("t5_drain");
    check("t5_npk", 32'(got.size()), 6);
    check("t5_first_pak", 32'(got[0]), 32'(redun(6'd40, 6'd2, 4'd6)));

    // i_req lands on the exact edge the hold buffer is emptied.
    ack_dly = 0;
    ack_en = 1'b0;
    got.delete();
    send_msg(6'd1, 6'd2, 4'd3, 1'b0);
    send_msg(6'd4, 6'd5, 4'd6, 1'b0);
    for (int k = 0; k < 6; k++) man_ack();
    i_src = 6'd33; i_dst = 6'd44; i_dat = 4'd11; i_red = redun(6'd33, 6'd44, 4'd11); i_req = 1'b1;
    push_exp(6'd33, 6'd44, 4'd11, redun(6'd33, 6'd44, 4'd11));
    @(negedge clk);
    check("t6_i_ack_early", 32'(i_ack), 0);
    check("t6_b_loaded", 32'(o_req), 1);
    @(negedge clk);
    check("t6_i_ack", 32'(i_ack), 1);
    i_req = 1'b0;
    n = 0;
    while (i_ack && n < 50) begin @(negedge clk); n++; end
    check("t6_i_ack_fall", 32'(i_ack), 0);
    ack_en = 1'b1;
    wait_idle("t6_drain");
    check("t6_npk", 32'(got.size()), 18);

    check("pak_stable", 32'(stab_bad), 0);
    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
